// File: rtl/ddr2_rank_timing_checker.sv
// Passive DDR2 command-bus monitor: tracks bank open state and timing per rank.
// Ports: clk/rstn, per-rank cke/cs_n, ras_n/cas_n/we_n/ba/addr in; open_mask, err_* out.
module ddr2_rank_timing_checker #(
  parameter int RANKS  = 2,
  parameter int BANKS  = 8,
  parameter int ADDR_W = 14,
  parameter int T_RCD  = 4,
  parameter int T_RP   = 4,
  parameter int T_RAS  = 12,
  parameter int T_RFC  = 51
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [RANKS-1:0]           cke,
  input  logic [RANKS-1:0]           cs_n,
  input  logic                       ras_n,
  input  logic                       cas_n,
  input  logic                       we_n,
  input  logic [$clog2(BANKS)-1:0]   ba,
  input  logic [ADDR_W-1:0]          addr,
  output logic [RANKS*BANKS-1:0]     open_mask,
  output logic                       err_valid,
  output logic [3:0]                 err_code,
  output logic [1:0]                 err_rank,
  output logic [2:0]                 err_bank,
  output logic [15:0]                err_cnt
);

  localparam int BW = $clog2(BANKS);
  localparam int RW = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam int MAXT =
    (T_RAS > T_RCD) ? ((T_RAS > T_RP) ? T_RAS : T_RP)
                    : ((T_RCD > T_RP) ? T_RCD : T_RP);
  localparam int CW  = $clog2(MAXT + 1);
  localparam int RFW = $clog2(T_RFC + 1);

  localparam logic [CW-1:0]  MAX_C  = CW'(MAXT);
  localparam logic [CW-1:0]  RCD_C  = CW'(T_RCD);
  localparam logic [CW-1:0]  RP_C   = CW'(T_RP);
  localparam logic [CW-1:0]  RAS_C  = CW'(T_RAS);
  localparam logic [CW-1:0]  ONE_C  = CW'(1);
  localparam logic [RFW-1:0] RFC_LD = RFW'(T_RFC - 1);

  // Bank/rank state
  logic [RANKS-1:0][BANKS-1:0] active_q;
  logic [CW-1:0]               act_age [RANKS][BANKS];
  logic [CW-1:0]               pre_age [RANKS][BANKS];
  logic [RFW-1:0]              rfc_q   [RANKS];

  // Decode
  logic [2:0]    nlow;
  logic [RW-1:0] rk;
  logic          multi;
  logic          sel;
  logic          is_nop;
  logic          is_act;
  logic          is_rd;
  logic          is_wr;
  logic          is_pre;
  logic          is_ref;
  logic          is_rw;

  logic unused_addr;
  assign unused_addr = ^{addr[ADDR_W-1:11], addr[9:0]};

  always_comb begin
    nlow = '0;
    rk   = '0;
    for (int r = 0; r < RANKS; r++) begin
      if (!cs_n[r]) begin
        nlow = nlow + 3'd1;
        rk   = RW'(r);
      end
    end
    multi = (nlow > 3'd1);
    sel   = (nlow == 3'd1) && cke[rk];
  end

  always_comb begin
    is_nop = 1'b0;
    is_act = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_pre = 1'b0;
    is_ref = 1'b0;
    unique case ({ras_n, cas_n, we_n})
      3'b111:  is_nop = 1'b1;
      3'b011:  is_act = 1'b1;
      3'b101:  is_rd  = 1'b1;
      3'b100:  is_wr  = 1'b1;
      3'b010:  is_pre = 1'b1;
      3'b001:  is_ref = 1'b1;
      default: ;
    endcase
    is_rw = is_rd | is_wr;
  end

  // Per-bank update strobes for the selected rank
  logic [RANKS-1:0][BANKS-1:0] act_hit;
  logic [RANKS-1:0][BANKS-1:0] pre_hit;
  logic [RANKS-1:0]            ref_hit;

  always_comb begin
    act_hit = '0;
    pre_hit = '0;
    ref_hit = '0;
    for (int r = 0; r < RANKS; r++) begin
      if (sel && (rk == RW'(r))) begin
        ref_hit[r] = is_ref;
        for (int b = 0; b < BANKS; b++) begin
          act_hit[r][b] = is_act && (ba == BW'(b));
          pre_hit[r][b] = is_pre &&
                          (addr[10] || (ba == BW'(b)));
        end
      end
    end
  end

  // Violation check; lowest code wins
  logic [3:0]    code;
  logic [1:0]    vrank;
  logic [2:0]    vbank;
  logic          p4;
  logic [BW-1:0] pbank;
  logic          any_act;
  logic          busy;
  logic          b_act;

  always_comb begin
    code    = '0;
    vrank   = '0;
    vbank   = '0;
    p4      = 1'b0;
    pbank   = '0;
    any_act = |active_q[rk];
    busy    = (rfc_q[rk] != '0);
    b_act   = active_q[rk][ba];
    // Descending scan so the lowest offending bank is reported
    for (int b = BANKS - 1; b >= 0; b--) begin
      if (is_pre && (addr[10] || (ba == BW'(b))) &&
          active_q[rk][b] && (act_age[rk][b] < RAS_C)) begin
        p4    = 1'b1;
        pbank = BW'(b);
      end
    end
    if (multi) begin
      code = 4'd8;
    end else if (sel) begin
      vrank = 2'(rk);
      if (is_act && b_act) begin
        code  = 4'd1;
        vbank = 3'(ba);
      end else if (is_rw && !b_act) begin
        code  = 4'd2;
        vbank = 3'(ba);
      end else if (is_rw && (act_age[rk][ba] < RCD_C)) begin
        code  = 4'd3;
        vbank = 3'(ba);
      end else if (p4) begin
        code  = 4'd4;
        vbank = 3'(pbank);
      end else if (is_act && (pre_age[rk][ba] < RP_C)) begin
        code  = 4'd5;
        vbank = 3'(ba);
      end else if (is_ref && any_act) begin
        code  = 4'd6;
      end else if (!is_nop && busy) begin
        code  = 4'd7;
      end
      if (code == 4'd0) begin
        vrank = '0;
        vbank = '0;
      end
    end
  end

  // Ages count cycles since the command as seen by the next
  // sampled command, so a command N cycles later sees age N.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= '0;
      for (int r = 0; r < RANKS; r++) begin
        rfc_q[r] <= '0;
        for (int b = 0; b < BANKS; b++) begin
          act_age[r][b] <= MAX_C;
          pre_age[r][b] <= MAX_C;
        end
      end
    end else begin
      for (int r = 0; r < RANKS; r++) begin
        if (ref_hit[r])
          rfc_q[r] <= RFC_LD;
        else if (rfc_q[r] != '0)
          rfc_q[r] <= rfc_q[r] - RFW'(1);
        for (int b = 0; b < BANKS; b++) begin
          if (act_hit[r][b])
            active_q[r][b] <= 1'b1;
          else if (pre_hit[r][b])
            active_q[r][b] <= 1'b0;
          if (act_hit[r][b])
            act_age[r][b] <= ONE_C;
          else if (act_age[r][b] != MAX_C)
            act_age[r][b] <= act_age[r][b] + ONE_C;
          if (pre_hit[r][b])
            pre_age[r][b] <= ONE_C;
          else if (pre_age[r][b] != MAX_C)
            pre_age[r][b] <= pre_age[r][b] + ONE_C;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_valid <= 1'b0;
      err_code  <= '0;
      err_rank  <= '0;
      err_bank  <= '0;
      err_cnt   <= '0;
    end else begin
      err_valid <= (code != 4'd0);
      err_code  <= code;
      err_rank  <= vrank;
      err_bank  <= vbank;
      if ((code != 4'd0) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

  assign open_mask = active_q;

endmodule

// File: tb/tb_ddr2_rank_timing_checker.sv
// Bench for ddr2_rank_timing_checker: directed steps plus random traffic
// checked against a time-stamp based reference model.
module tb_ddr2_rank_timing_checker;

  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_RAS = 12;
  localparam int T_RFC = 51;

  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] PRE = 3'b010;
  localparam logic [2:0] REF = 3'b001;
  localparam logic [2:0] MRS = 3'b000;

  logic        clk;
  logic        rstn;
  logic [1:0]  cke;
  logic [1:0]  cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic [15:0] open_mask;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [1:0]  err_rank;
  logic [2:0]  err_bank;
  logic [15:0] err_cnt;

  ddr2_rank_timing_checker dut (
    .clk       (clk),
    .rstn      (rstn),
    .cke       (cke),
    .cs_n      (cs_n),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .ba        (ba),
    .addr      (addr),
    .open_mask (open_mask),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_rank  (err_rank),
    .err_bank  (err_bank),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: open flags plus cycle stamps of last ACT/PRE/REF
  bit act [2][8];
  int la  [2][8];
  int lp  [2][8];
  int lr  [2];
  int cyc;
  int ecnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      lr[r] = -1000;
      for (int b = 0; b < 8; b++) begin
        act[r][b] = 1'b0;
        la[r][b]  = -1000;
        lp[r][b]  = -1000;
      end
    end
    ecnt = 0;
  endtask

  task automatic step(input logic [1:0] ck, input logic [1:0] cs,
                      input logic [2:0] cmd, input int b, input bit a10);
    int nl, r, p4b;
    bit any, isrw;
    logic [3:0]  ec;
    logic [1:0]  er;
    logic [2:0]  eb;
    logic [15:0] em;
    cke  = ck;
    cs_n = cs;
    {ras_n, cas_n, we_n} = cmd;
    ba   = 3'(b);
    addr = 14'($urandom);
    addr[10] = a10;
    ec = 0; er = 0; eb = 0; nl = 0; r = 0;
    isrw = (cmd == RD) || (cmd == WR);
    for (int i = 0; i < 2; i++)
      if (!cs[i]) begin nl++; r = i; end
    if (nl > 1) begin
      ec = 4'd8;
    end else if (nl == 1 && ck[r]) begin
      p4b = -1;
      any = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        if (act[r][i]) any = 1'b1;
        if (cmd == PRE && (a10 || i == b) && act[r][i] &&
            cyc - la[r][i] < T_RAS) p4b = i;
      end
      if (cmd == ACT && act[r][b]) begin
        ec = 1; eb = 3'(b);
      end else if (isrw && !act[r][b]) begin
        ec = 2; eb = 3'(b);
      end else if (isrw && cyc - la[r][b] < T_RCD) begin
        ec = 3; eb = 3'(b);
      end else if (p4b >= 0) begin
        ec = 4; eb = 3'(p4b);
      end else if (cmd == ACT && cyc - lp[r][b] < T_RP) begin
        ec = 5; eb = 3'(b);
      end else if (cmd == REF && any) begin
        ec = 6;
      end else if (cmd != NOP && cyc - lr[r] < T_RFC) begin
        ec = 7;
      end
      if (ec != 0) er = 2'(r);
      if (cmd == ACT) begin
        act[r][b] = 1'b1;
        la[r][b]  = cyc;
      end
      if (cmd == PRE)
        for (int i = 0; i < 8; i++)
          if (a10 || i == b) begin
            act[r][i] = 1'b0;
            lp[r][i]  = cyc;
          end
      if (cmd == REF) lr[r] = cyc;
    end
    if (ec != 0 && ecnt < 65535) ecnt++;
    for (int i = 0; i < 16; i++) em[i] = act[i / 8][i % 8];
    @(posedge clk);
    #1;
    chk("err_valid", 32'(err_valid), 32'(ec != 0));
    chk("err_info", {21'd0, err_code, err_rank, err_bank},
        {21'd0, ec, er, eb});
    chk("open_mask", 32'(open_mask), 32'(em));
    chk("err_cnt", 32'(err_cnt), 32'(ecnt));
    cyc++;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(2'b11, 2'b11, NOP, 0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mask"}, 32'(open_mask), 32'd0);
    chk({tag, "_err"}, {23'd0, err_valid, err_code, err_rank, err_bank},
        32'd0);
    chk({tag, "_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  logic [2:0] ctab [11];
  int base;

  initial begin
    ctab = '{NOP, NOP, NOP, ACT, ACT, RD, WR, PRE, PRE, REF, MRS};
    cke = 2'b11; cs_n = 2'b11;
    {ras_n, cas_n, we_n} = NOP;
    ba = '0; addr = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1 chk_zero("reset");
    model_reset();
    cyc = 0;
    #10 rstn = 1'b1;

    // 1: ACT/RD/PRE at legal distances on rank 0 bank 3
    step(2'b11, 2'b10, ACT, 3, 1'b0);
    chk("t1_open", 32'(open_mask[3]), 32'd1);
    nops(3);
    step(2'b11, 2'b10, RD, 3, 1'b0);
    nops(7);
    step(2'b11, 2'b10, PRE, 3, 1'b0);
    chk("t1_closed", 32'(open_mask[3]), 32'd0);
    chk("t1_cnt", 32'(err_cnt), 32'd0);

    // 2: tRCD violation on rank 1 bank 2
    step(2'b11, 2'b01, ACT, 2, 1'b0);
    nops(1);
    step(2'b11, 2'b01, RD, 2, 1'b0);
    chk("t2_code", {err_valid, err_code, err_rank, err_bank},
        {1'b1, 4'd3, 2'd1, 3'd2});
    chk("t2_cnt", 32'(err_cnt), 32'd1);
    nops(1);
    chk("t2_pulse", 32'(err_valid), 32'd0);

    // 3: tRAS then tRP violations on rank 0 bank 0
    step(2'b11, 2'b10, ACT, 0, 1'b0);
    nops(4);
    step(2'b11, 2'b10, PRE, 0, 1'b0);
    chk("t3_ras", 32'(err_code), 32'd4);
    nops(1);
    step(2'b11, 2'b10, ACT, 0, 1'b0);
    chk("t3_rp", 32'(err_code), 32'd5);
    chk("t3_cnt", 32'(err_cnt), 32'd3);

    // 4: double ACT, then REF with open banks
    step(2'b11, 2'b10, ACT, 1, 1'b0);
    nops(19);
    step(2'b11, 2'b10, ACT, 1, 1'b0);
    chk("t4_dup", 32'(err_code), 32'd1);
    step(2'b11, 2'b10, REF, 0, 1'b0);
    chk("t4_ref", {err_valid, err_code, err_bank}, {1'b1, 4'd6, 3'd0});

    // 5: refresh window boundaries
    nops(55);
    step(2'b11, 2'b10, PRE, 0, 1'b1);
    chk("t5_preall", 32'(err_valid), 32'd0);
    step(2'b11, 2'b10, REF, 0, 1'b0);
    base = cyc - 1;
    nops(9);
    step(2'b11, 2'b10, ACT, 4, 1'b0);
    chk("t5_rfc", 32'(err_code), 32'd7);
    nops(T_RFC - (cyc - base));
    step(2'b11, 2'b10, ACT, 5, 1'b0);
    chk("t5_ok", 32'(err_valid), 32'd0);

    // 6: multiple chip selects; command ignored
    step(2'b11, 2'b00, ACT, 6, 1'b0);
    chk("t6_multi", {err_valid, err_code, err_rank, err_bank},
        {1'b1, 4'd8, 2'd0, 3'd0});
    chk("t6_mask", 32'(open_mask[6] | open_mask[14]), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [1:0] ck, cs;
      int sel;
      ck  = {1'($urandom % 8 != 0), 1'($urandom % 8 != 0)};
      sel = int'($urandom % 10);
      if (sel == 0) begin
        step(ck, 2'b00, ACT, int'($urandom % 8), 1'b0);
      end else begin
        cs = (sel == 1) ? 2'b11 : ~(2'b01 << ($urandom % 2));
        step(ck, cs, ctab[$urandom % 11], int'($urandom % 8),
             1'($urandom));
      end
    end

    // Asynchronous reset in the middle of traffic
    step(2'b11, 2'b10, ACT, 7, 1'b0);
    #2 rstn = 1'b0;
    #1 chk_zero("midreset");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(2'b11, 2'b10, ACT, 7, 1'b0);
    chk("post_act", {err_valid, 15'(err_cnt)}, 16'd0);
    nops(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
